// File: rtl/latency_spike_encoder_if.sv
// Value-vector handshake between a producer and the latency spike encoder.
// Debug build option (encoder side): LATENCY_ENC_DEBUG_EN.
interface latency_spike_encoder_if #(
  parameter int M     = 8,
  parameter int Nbits = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [M*Nbits-1:0] in_values;

  modport master (
    output in_valid,
    output in_values,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_values,
    output in_ready
  );
endinterface

// File: rtl/latency_spike_encoder.sv
// Time-to-first-spike encoder: replays a value vector over a 2^Nbits-1 step window.
// Optional macro LATENCY_ENC_DEBUG_EN adds the step_out port.
module latency_spike_encoder #(
  parameter int M     = 8,
  parameter int Nbits = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  latency_spike_encoder_if.slave   in_if,
  output logic [M-1:0]             spikes_out,
  output logic                     busy,
  output logic                     window_done
`ifdef LATENCY_ENC_DEBUG_EN
  ,
  output logic [Nbits-1:0]         step_out
`endif
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [Nbits-1:0] WMAX = '1;
  localparam logic [Nbits-1:0] LAST = ~Nbits'(1);

  state_t             state;
  logic [Nbits-1:0]   step;
  logic [M*Nbits-1:0] vals;
  logic [M-1:0]       fire;
  logic [Nbits-1:0]   lane;

  assign in_if.in_ready = (state == IDLE);
  assign busy           = (state == RUN);

`ifdef LATENCY_ENC_DEBUG_EN
  assign step_out = step;
`endif

  // Lane fires when the step reaches its time-to-first-spike (WMAX - value).
  always_comb begin
    fire = '0;
    lane = '0;
    for (int i = 0; i < M; i++) begin
      lane    = vals[i*Nbits +: Nbits];
      fire[i] = (lane != '0) && (step == WMAX - lane);
    end
  end

  // Window FSM: accept in IDLE, step through the window in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      step        <= '0;
      vals        <= '0;
      spikes_out  <= '0;
      window_done <= 1'b0;
    end else begin
      spikes_out  <= '0;
      window_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_if.in_valid && enable) begin
            vals  <= in_if.in_values;
            step  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (enable) begin
            spikes_out <= fire;
            if (step == LAST) begin
              window_done <= 1'b1;
              step        <= '0;
              state       <= IDLE;
            end else begin
              step <= step + Nbits'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/latency_spike_encoder.md
# latency_spike_encoder

- Transmit-side front end for the LIF neuron array.
- Accepts one vector of M unsigned Nbits input intensities per handshake and replays it as a time-to-first-spike train on an M-bit spike bus over a fixed window of 2^Nbits−1 steps. Larger values fire earlier; zero never fires.
- Its spike bus drives the neurons' input-spike port directly. It shares the neurons' clk/reset/enable so steps line up with neuron integration cycles.

## Interface
Parameters:
- M, 8, number of spike lanes / input values
- Nbits, 2, value precision; the window is 2^Nbits−1 steps

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous reset, active high
- enable  input  1  global step enable, shared with the neurons
- in_valid  input  1  producer has a value vector
- in_ready  output  1  encoder can accept; high exactly when in IDLE
- in_values  input  M*Nbits  lane i value at [i*Nbits +: Nbits]
- spikes_out  output  M  registered spike bus, one bit per lane
- busy  output  1  high in RUN
- window_done  output  1  one-cycle pulse coincident with the last step's spikes
- step_out  output  Nbits  current step counter (present only with LATENCY_ENC_DEBUG_EN)

## Operation
- States:
  - IDLE (reset state)
  - RUN
- Accept:
  - Accept occurs on a rising edge with in_valid & in_ready & enable.
  - On accept, latch in_values, clear step to 0, go to RUN.
  - in_valid while not ready is ignored; the producer holds its data.
- RUN, each edge with enable=1:
  - spikes_out[i] <= (v_i != 0) && (step == 2^Nbits−1−v_i).
  - step <= step+1.
  - When step == 2^Nbits−2, also: window_done <= 1 and state <= IDLE.
- RUN with enable=0:
  - step, state and latched values hold.
  - spikes_out <= 0 and window_done <= 0 (no stale spikes while the neurons are frozen).
- IDLE: spikes_out <= 0, window_done <= 0.
- Arithmetic:
  - Unsigned compare at Nbits width.
  - step never exceeds 2^Nbits−2; there is no wrap.
  - Nbits=1 gives a one-step window.
- Each lane spikes at most once per window.
- Reset mid-window:
  - Abort immediately.
  - All outputs and state go to their reset values.
  - The latched vector is discarded.

## Timing
- Reset values:
  - state IDLE, in_ready 1, busy 0
  - spikes_out 0, window_done 0, step 0
- Accept at edge E0. Step k spikes are visible in the cycle after edge E(k+1), for k = 0..2^Nbits−2, assuming enable stays high.
- window_done is high in the cycle after E(2^Nbits−1). in_ready is high again in that same cycle.
- Earliest next accept is E(2^Nbits). Spikes_out is 0 in the cycle after that edge.
- in_ready and busy are decoded from the state register, with no combinational path from in_valid.
- Low-enable cycles stretch the window one-for-one.

## Configuration
- LATENCY_ENC_DEBUG_EN:
  - Defined: adds the step_out port. It carries the step register, which is 0 in IDLE and after reset.
  - Undefined: the port is absent.
  - Functional behaviour of every other output is identical in both builds.

## Test plan
- Basic window:
  - Stimulus: M=8, Nbits=2, in_values=16'h1B1B (lanes 3,2,1,0,3,2,1,0), enable=1.
  - Response: spikes_out = 8'h11, 8'h22, 8'h44 on three consecutive cycles, then 0.
  - window_done is high only with 8'h44; in_ready is 0 for three cycles after accept.
- Back-to-back:
  - Stimulus: in_valid held high with 16'hFFFF, then 16'h5555.
  - Response: 8'hFF at step 0 of window 1.
  - 8'hFF at step 2 of window 2, with only zeros between.
  - Exactly one window_done per window.
- Enable stall:
  - Stimulus: 16'h1B1B, enable dropped for 2 cycles after the first spike.
  - Response: two zero cycles, then 8'h22, 8'h44.
  - step_out frozen at 1 during the stall in the debug build.
- Zero values:
  - Stimulus: in_values=16'h0000.
  - Response: spikes_out stays 0 for the whole window; window_done still pulses after 3 steps.
- Reset mid-window:
  - Stimulus: assert reset asynchronously between steps 0 and 1 of 16'h1B1B.
  - Response: spikes_out=0, busy=0, in_ready=1 immediately, with no spikes after release.
- Not-ready input:
  - Stimulus: in_valid pulsed during RUN with a different vector.
  - Response: the vector is ignored and the current window completes unchanged.
